// File: rtl/pc_fetch_sequencer_if.sv
// Fetch-side bus bundle: instruction-memory port, decode handoff and branch resolution.
interface pc_fetch_sequencer_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        resolve_valid;
   logic        resolve_taken;
   logic [31:0] resolve_imm;
   logic        resolve_neg;

   // Sequencer side
   modport master (
      output imem_req, imem_addr, instr_valid, instr, instr_pc,
      input  imem_ack, imem_rdata, instr_ready,
      input  resolve_valid, resolve_taken, resolve_imm, resolve_neg
   );

   // Memory / decode / execute side
   modport slave (
      input  imem_req, imem_addr, instr_valid, instr, instr_pc,
      output imem_ack, imem_rdata, instr_ready,
      output resolve_valid, resolve_taken, resolve_imm, resolve_neg
   );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Multicycle fetch controller: owns the PC, fetches from imem, hands the word to
// decode, waits for branch resolution and steps the PC to PC+4 or PC+/-imm.
module pc_fetch_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned TIMEOUT  = 16
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        run,
   pc_fetch_sequencer_if.master        bus,
   output logic                        fault,
   output logic [1:0]                  fault_code,
   output logic [31:0]                 retired
);

   localparam int unsigned CNT_W   = $clog2(TIMEOUT) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_FETCH   = 3'd1;
   localparam logic [2:0] S_ISSUE   = 3'd2;
   localparam logic [2:0] S_RESOLVE = 3'd3;
   localparam logic [2:0] S_FAULT   = 3'd4;

   localparam logic [1:0] CODE_NONE     = 2'd0;
   localparam logic [1:0] CODE_TIMEOUT  = 2'd1;
   localparam logic [1:0] CODE_MISALIGN = 2'd2;

   logic [2:0]       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [31:0]      pc, pc_nxt;
   logic [31:0]      instr_q, instr_nxt;
   logic [31:0]      instr_pc_q, instr_pc_nxt;
   logic [31:0]      retired_nxt;
   logic [31:0]      target_c;
   logic             fault_nxt;
   logic [1:0]       code_nxt;
   logic             req_q;
   logic             valid_q;

   // Branch/sequential target; 32-bit arithmetic wraps naturally
   always_comb begin
      target_c = pc + 32'd4;
      if (bus.resolve_taken) begin
         target_c = bus.resolve_neg ? (pc - bus.resolve_imm) : (pc + bus.resolve_imm);
      end
   end

   // Next-state and next-datapath decode
   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      pc_nxt       = pc;
      instr_nxt    = instr_q;
      instr_pc_nxt = instr_pc_q;
      retired_nxt  = retired;
      fault_nxt    = fault;
      code_nxt     = fault_code;

      case (state)
         S_IDLE: begin
            if (run) begin
               state_nxt = S_FETCH;
               cnt_nxt   = '0;
            end
         end
         S_FETCH: begin
            if (bus.imem_ack) begin
               instr_nxt    = bus.imem_rdata;
               instr_pc_nxt = pc;
               state_nxt    = S_ISSUE;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
               if (cnt_nxt == CNT_LAST) begin
                  state_nxt = S_FAULT;
                  fault_nxt = 1'b1;
                  code_nxt  = CODE_TIMEOUT;
               end
            end
         end
         S_ISSUE: begin
            if (bus.instr_ready) begin
               state_nxt = S_RESOLVE;
            end
         end
         S_RESOLVE: begin
            if (bus.resolve_valid) begin
               if (bus.resolve_taken && (target_c[1:0] != 2'b00)) begin
                  // Misaligned target: PC and retire count stay put
                  state_nxt = S_FAULT;
                  fault_nxt = 1'b1;
                  code_nxt  = CODE_MISALIGN;
               end else begin
                  pc_nxt      = target_c;
                  retired_nxt = retired + 32'd1;
                  cnt_nxt     = '0;
                  state_nxt   = run ? S_FETCH : S_IDLE;
               end
            end
         end
         S_FAULT: begin
            state_nxt = S_FAULT;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Datapath and registered handshake outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt        <= '0;
         pc         <= RESET_PC;
         instr_q    <= '0;
         instr_pc_q <= '0;
         retired    <= '0;
         fault      <= 1'b0;
         fault_code <= CODE_NONE;
         req_q      <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         cnt        <= cnt_nxt;
         pc         <= pc_nxt;
         instr_q    <= instr_nxt;
         instr_pc_q <= instr_pc_nxt;
         retired    <= retired_nxt;
         fault      <= fault_nxt;
         fault_code <= code_nxt;
         req_q      <= (state_nxt == S_FETCH);
         valid_q    <= (state_nxt == S_ISSUE);
      end
   end

   assign bus.imem_req    = req_q;
   assign bus.imem_addr   = pc;
   assign bus.instr_valid = valid_q;
   assign bus.instr       = instr_q;
   assign bus.instr_pc    = instr_pc_q;

endmodule
